// File: rtl/butterfly_seq_ctrl.sv
// Step-button sequencer for a radix-2 butterfly: loads twiddles and operands
// into the register file, gates the datapath, then pages through the results.
//
// state     | meaning
// LOAD_COEF | writing twiddle words, addra = idx
// LOAD_IN   | writing operand words, addra = N_COEF + idx
// CALC      | datapath running until Ready_dis
// SHOW      | stepping addr_led through the result words
module butterfly_seq_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int N_COEF      = 2,
  parameter int N_IN        = 4,
  parameter int N_OUT       = 4,
  parameter int RES_BASE    = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ReadyIn2,
  input  logic              Ready_dis,
  input  logic              reload_coef,
  output logic [ADDR_W-1:0] addra,
  output logic              reg_WEN,
  output logic [ADDR_W-1:0] addr_led,
  output logic              cal_flag,
  output logic              frame_done,
  output logic [7:0]        frame_cnt
);

  localparam int MAX_N = (N_COEF > N_IN) ? ((N_COEF > N_OUT) ? N_COEF : N_OUT)
                                         : ((N_IN > N_OUT) ? N_IN : N_OUT);
  localparam int IDX_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  localparam logic [IDX_W-1:0]  COEF_LAST = IDX_W'(N_COEF - 1);
  localparam logic [IDX_W-1:0]  IN_LAST   = IDX_W'(N_IN - 1);
  localparam logic [IDX_W-1:0]  OUT_LAST  = IDX_W'(N_OUT - 1);
  localparam logic [ADDR_W-1:0] IN_OFS    = ADDR_W'(N_COEF);
  localparam logic [ADDR_W-1:0] LED_BASE  = ADDR_W'(RES_BASE);
  localparam logic [ADDR_W-1:0] LED_LAST  = ADDR_W'(RES_BASE + N_OUT - 1);

  if (!((N_COEF + N_IN <= RES_BASE) && (RES_BASE + N_OUT <= 2**ADDR_W) &&
        (N_COEF >= 1) && (N_IN >= 1) && (N_OUT >= 1) && (SYNC_STAGES >= 2)))
  begin : g_param_check
    $error("butterfly_seq_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {LOAD_COEF, LOAD_IN, CALC, SHOW} state_t;

  state_t                 state, state_n;
  logic [IDX_W-1:0]       idx, idx_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   step;
  logic                   cnt_inc;

  // Flops reset high so a button held through reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ReadyIn2};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign step = sync_q[SYNC_STAGES-1] & ~hist_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= LOAD_COEF;
      idx       <= '0;
      frame_cnt <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (cnt_inc) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    addra      = '0;
    reg_WEN    = 1'b0;
    addr_led   = LED_LAST;
    cal_flag   = 1'b0;
    frame_done = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      LOAD_COEF: begin
        addra   = ADDR_W'(idx);
        reg_WEN = step;
        if (step) begin
          if (idx == COEF_LAST) begin
            state_n = LOAD_IN;
            idx_n   = '0;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      LOAD_IN: begin
        addra   = IN_OFS + ADDR_W'(idx);
        reg_WEN = step;
        if (step) begin
          if (idx == IN_LAST) begin
            state_n = CALC;
            idx_n   = '0;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      CALC: begin
        cal_flag = !Ready_dis;
        addr_led = LED_BASE;
        if (Ready_dis) begin
          state_n = SHOW;
          idx_n   = '0;
        end
      end
      SHOW: begin
        addr_led = LED_BASE + ADDR_W'(idx);
        if (step) begin
          if (idx == OUT_LAST) begin
            frame_done = 1'b1;
            cnt_inc    = 1'b1;
            state_n    = reload_coef ? LOAD_COEF : LOAD_IN;
            idx_n      = '0;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      default: begin
        state_n = LOAD_COEF;
        idx_n   = '0;
      end
    endcase
  end

endmodule
